// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for conv layer A2
package conv_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int KERNEL_SIZE = 5;
   localparam int IFM_SIZE    = 14;
   localparam int OFM_SIZE    = IFM_SIZE - KERNEL_SIZE + 1;
   // Taps go out two per cycle; the final pair carries only the odd last tap.
   localparam int LAST_PAIR   = (KERNEL_SIZE * KERNEL_SIZE - 1) / 2;

endpackage

// File: rtl/ifm_window_reader_if.sv
// rtl/ifm_window_reader_if.sv - control, memory-port and MAC-strobe bundle of the IFM window reader
interface ifm_window_reader_if #(
   parameter int ADDRESS_SIZE_IFM = 8
);
   logic                        start;
   logic                        ready;
   logic [ADDRESS_SIZE_IFM-1:0] Address_A;
   logic [ADDRESS_SIZE_IFM-1:0] Address_B;
   logic                        Enable_Read_A;
   logic                        Enable_Read_B;
   logic                        Enable_Write_A_Mem;
   logic                        Enable_Write_B_Mem;
   logic                        valid_a;
   logic                        valid_b;
   logic [4:0]                  tap_a;
   logic                        window_last;
   logic [3:0]                  ofm_row;
   logic [3:0]                  ofm_col;
   logic                        busy;
   logic                        done;

   modport master (
      input  start, ready,
      output Address_A, Address_B, Enable_Read_A, Enable_Read_B,
             Enable_Write_A_Mem, Enable_Write_B_Mem,
             valid_a, valid_b, tap_a, window_last, ofm_row, ofm_col, busy, done
   );

   modport slave (
      output start, ready,
      input  Address_A, Address_B, Enable_Read_A, Enable_Read_B,
             Enable_Write_A_Mem, Enable_Write_B_Mem,
             valid_a, valid_b, tap_a, window_last, ofm_row, ofm_col, busy, done
   );

endinterface

// File: rtl/ifm_tap_addr.sv
// rtl/ifm_tap_addr.sv - maps (window row, window col, kernel tap) to a flat IFM word address
module ifm_tap_addr #(
   parameter int IFM_SIZE    = 14,
   parameter int KERNEL_SIZE = 5,
   parameter int ADDR_W      = 8
) (
   input  logic [3:0]        i_row,
   input  logic [3:0]        i_col,
   input  logic [4:0]        i_k,
   output logic [ADDR_W-1:0] o_addr
);

   logic [4:0] w_kr;
   logic [4:0] w_kc;

   assign w_kr   = i_k / 5'(KERNEL_SIZE);
   assign w_kc   = i_k % 5'(KERNEL_SIZE);
   assign o_addr = (ADDR_W'(i_row) + ADDR_W'(w_kr)) * ADDR_W'(IFM_SIZE)
                 + ADDR_W'(i_col) + ADDR_W'(w_kc);

endmodule

// File: rtl/ifm_window_reader.sv
// rtl/ifm_window_reader.sv - raster walk of all 5x5 IFM windows, two taps per cycle on ports A/B
// Strobes toward the MAC trail the issued addresses by the one-cycle memory read latency.
module ifm_window_reader #(
   parameter int DATA_WIDTH       = 32,
   parameter int IFM_SIZE         = 14,
   parameter int KERNEL_SIZE      = 5,
   parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE * IFM_SIZE)
) (
   input  logic                clk,
   input  logic                rst,
   ifm_window_reader_if.master bus
);
   import conv_pkg::*;

   localparam int OFM_SIZE = IFM_SIZE - KERNEL_SIZE + 1;
   localparam int AW       = ADDRESS_SIZE_IFM;

   if (DATA_WIDTH < 1 || AW != $clog2(IFM_SIZE * IFM_SIZE) || OFM_SIZE < 1 || OFM_SIZE > 16
       || (KERNEL_SIZE * KERNEL_SIZE - 1) / 2 != LAST_PAIR) begin : g_bad_cfg
      $error("ifm_window_reader: inconsistent geometry parameters");
   end

   state_t          r_state;
   state_t          w_state_nxt;
   logic [3:0]      r_row;
   logic [3:0]      r_col;
   logic [3:0]      r_pair;
   logic            w_issue;
   logic            w_last_pair;
   logic            w_last_col;
   logic            w_last_row;
   logic [4:0]      w_k_a;
   logic [4:0]      w_k_b;
   logic [AW-1:0]   w_addr_a;
   logic [AW-1:0]   w_addr_b;

   logic [AW-1:0]   r_addr_a;
   logic [AW-1:0]   r_addr_b;
   logic            r_en_a;
   logic            r_en_b;
   logic [4:0]      r_iss_tap;
   logic            r_iss_last;
   logic [3:0]      r_iss_row;
   logic [3:0]      r_iss_col;
   logic            r_valid_a;
   logic            r_valid_b;
   logic [4:0]      r_tap_a;
   logic            r_window_last;
   logic [3:0]      r_ofm_row;
   logic [3:0]      r_ofm_col;
   logic            r_done;

   assign w_last_pair = (r_pair == 4'(LAST_PAIR));
   assign w_last_col  = (r_col == 4'(OFM_SIZE - 1));
   assign w_last_row  = (r_row == 4'(OFM_SIZE - 1));
   assign w_k_a       = {r_pair, 1'b0};
   assign w_k_b       = {r_pair, 1'b1};

   ifm_tap_addr #(
      .IFM_SIZE    (IFM_SIZE),
      .KERNEL_SIZE (KERNEL_SIZE),
      .ADDR_W      (AW)
   ) u_addr_a (
      .i_row  (r_row),
      .i_col  (r_col),
      .i_k    (w_k_a),
      .o_addr (w_addr_a)
   );

   ifm_tap_addr #(
      .IFM_SIZE    (IFM_SIZE),
      .KERNEL_SIZE (KERNEL_SIZE),
      .ADDR_W      (AW)
   ) u_addr_b (
      .i_row  (r_row),
      .i_col  (r_col),
      .i_k    (w_k_b),
      .o_addr (w_addr_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.ready) begin
               w_issue = 1'b1;
               if (w_last_pair && w_last_col && w_last_row) begin
                  w_state_nxt = S_DRAIN;
               end
            end
         end
         S_DRAIN: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pair counter is innermost, then column, then row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row  <= '0;
         r_col  <= '0;
         r_pair <= '0;
      end else if (r_state == S_IDLE) begin
         r_row  <= '0;
         r_col  <= '0;
         r_pair <= '0;
      end else if (w_issue) begin
         if (w_last_pair) begin
            r_pair <= '0;
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? 4'd0 : r_row + 4'd1;
            end else begin
               r_col <= r_col + 4'd1;
            end
         end else begin
            r_pair <= r_pair + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_a   <= '0;
         r_addr_b   <= '0;
         r_en_a     <= 1'b0;
         r_en_b     <= 1'b0;
         r_iss_tap  <= '0;
         r_iss_last <= 1'b0;
         r_iss_row  <= '0;
         r_iss_col  <= '0;
      end else begin
         r_en_a <= w_issue;
         r_en_b <= w_issue && !w_last_pair;
         if (w_issue) begin
            r_addr_a   <= w_addr_a;
            r_iss_tap  <= w_k_a;
            r_iss_last <= w_last_pair;
            r_iss_row  <= r_row;
            r_iss_col  <= r_col;
            if (!w_last_pair) begin
               r_addr_b <= w_addr_b;
            end
         end
      end
   end

   // Second stage lines the strobes up with the read data leaving the memories.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid_a     <= 1'b0;
         r_valid_b     <= 1'b0;
         r_tap_a       <= '0;
         r_window_last <= 1'b0;
         r_ofm_row     <= '0;
         r_ofm_col     <= '0;
         r_done        <= 1'b0;
      end else begin
         r_valid_a     <= r_en_a;
         r_valid_b     <= r_en_b;
         r_tap_a       <= r_iss_tap;
         r_window_last <= r_en_a && r_iss_last;
         r_ofm_row     <= r_iss_row;
         r_ofm_col     <= r_iss_col;
         r_done        <= (r_state == S_DONE);
      end
   end

   assign bus.Address_A          = r_addr_a;
   assign bus.Address_B          = r_addr_b;
   assign bus.Enable_Read_A      = r_en_a;
   assign bus.Enable_Read_B      = r_en_b;
   assign bus.Enable_Write_A_Mem = 1'b0;
   assign bus.Enable_Write_B_Mem = 1'b0;
   assign bus.valid_a            = r_valid_a;
   assign bus.valid_b            = r_valid_b;
   assign bus.tap_a              = r_tap_a;
   assign bus.window_last        = r_window_last;
   assign bus.ofm_row            = r_ofm_row;
   assign bus.ofm_col            = r_ofm_col;
   assign bus.busy               = (r_state == S_FETCH) || (r_state == S_DRAIN);
   assign bus.done               = r_done;

endmodule
